// File: rtl/frame_pkg.sv
// Shared definitions for the serial frame link (transmitter and receiver).
package frame_pkg;

    localparam logic [7:0] HEADER     = 8'hA5;
    localparam int         FRAME_BITS = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY,
        ST_GAP
    } xmtr_state_t;

endpackage

// File: rtl/xmtr.sv
// Serial frame transmitter: one-deep holding register feeding a header+byte
// shifter, MSB first, one bit per clock, line idles low.
module xmtr
    import frame_pkg::*;
#(
    parameter int GAP = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       writing,
    output logic       full,
    output logic       busy,
    output logic       overrun,
    output logic       serial_out
);

    if (GAP < 0 || GAP > 15) begin : g_gap_check
        $error("xmtr: GAP must be in the range 0..15");
    end

    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    xmtr_state_t state;
    logic [7:0]  hold;
    logic [7:0]  shreg;
    logic [2:0]  bitcnt;
    logic [3:0]  gapcnt;
    logic        take;
    logic        accept;

    // bitcnt wraps to 7 once bit 0 is on the line, marking the last bit cycle.
    assign take = full && ((state == ST_IDLE) ||
                           (state == ST_BODY && bitcnt == 3'd7 && GAP == 0) ||
                           (state == ST_GAP  && gapcnt == 4'd0));
    assign accept = writing && (!full || take);

    always_ff @(posedge clock) begin
        if (take) begin
            shreg <= hold;
        end
        if (accept) begin
            hold <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            serial_out <= 1'b0;
            busy       <= 1'b0;
            full       <= 1'b0;
            overrun    <= 1'b0;
            bitcnt     <= 3'd0;
            gapcnt     <= 4'd0;
        end else begin
            if (accept) begin
                full    <= 1'b1;
                overrun <= 1'b0;
            end else begin
                if (take) begin
                    full <= 1'b0;
                end
                if (writing) begin
                    overrun <= 1'b1;
                end
            end

            if (take) begin
                state      <= ST_HEAD;
                serial_out <= HEADER[7];
                bitcnt     <= 3'd6;
                busy       <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        serial_out <= 1'b0;
                        busy       <= 1'b0;
                    end
                    ST_HEAD: begin
                        if (bitcnt == 3'd7) begin
                            state      <= ST_BODY;
                            serial_out <= shreg[7];
                            bitcnt     <= 3'd6;
                        end else begin
                            serial_out <= HEADER[bitcnt];
                            bitcnt     <= bitcnt - 3'd1;
                        end
                    end
                    ST_BODY: begin
                        if (bitcnt == 3'd7) begin
                            serial_out <= 1'b0;
                            if (GAP > 0) begin
                                state  <= ST_GAP;
                                gapcnt <= GAP_LAST;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            serial_out <= shreg[bitcnt];
                            bitcnt     <= bitcnt - 3'd1;
                        end
                    end
                    ST_GAP: begin
                        serial_out <= 1'b0;
                        if (gapcnt == 4'd0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gapcnt <= gapcnt - 4'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
